btn_event_arbiter: RTL
======================

# btn_event_arbiter

Collects press events from up to `N_BTN` asynchronous push-buttons and serialises them onto one command channel toward the counter/display controller. Each button is synchronised, rising-edge detected and locked out for a programmable dwell to reject bounce. Events are queued as one pending bit per button, granted round-robin, and offered over a valid/ready handshake. Sits between the board buttons and the multi-counter control logic.

## Interface

Parameters:
- `N_BTN`, 4: number of buttons, from 2 to 16.
- `LOCKOUT_CYC`, 2_000_000: cycles during which further rises on the same button are ignored after an accepted rise (20 ms at 100 MHz). Minimum 1.
- `ID_W`, `$clog2(N_BTN)`: width of the button index. Derived; not overridden.

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset. **One clock; reset is asynchronous and active-low.**
- `btn`, in, `N_BTN`: raw asynchronous button levels, active-high.
- `cmd_valid`, out, 1: a command is offered.
- `cmd_id`, out, `ID_W`: index of the button being offered.
- `cmd_ready`, in, 1: the consumer accepts the command.
- `ovr`, out, `N_BTN`: sticky per-button overrun flags.
- `ovr_clr`, in, 1: synchronous clear of all `ovr` bits.

## Operation

- Per-button front end:
  - 3-flop synchroniser chain `s0 -> s1 -> s2`.
  - `rise[i] = s1 & ~s2`.
- Lockout:
  - A per-button counter `lock[i]` loads `LOCKOUT_CYC-1` when `rise[i]` is accepted, then decrements to 0.
  - A rise is accepted only when `lock[i]==0`.
  - Rises during lockout are silently dropped and do not set `ovr`.
- Pending:
  - An accepted rise sets `pend[i]`.
  - If `pend[i]` is already 1, `ovr[i]` is also set.
  - If an accepted rise and a handshake clear of `pend[i]` occur in the same cycle, the set wins: `pend[i]` stays 1 and `ovr` is unchanged.
- `ovr_clr`:
  - Clears all `ovr` bits.
  - A new overrun in the same cycle wins for that bit.
- FSM, two states:
  - IDLE: `cmd_valid=0`. If any `pend` bit is set, select the first set bit scanning upward from `last+1`, wrapping modulo `N_BTN`. Register the index into `cmd_id` and go to OFFER.
  - OFFER: `cmd_valid=1` and `cmd_id` is held stable. On `cmd_valid & cmd_ready`, clear `pend[cmd_id]`, set `last<=cmd_id`, and go to IDLE.
- The grant is never withdrawn while `cmd_ready` is low. New pends do not change the offered `cmd_id`.
- Reset values:
  - All sync flops, `lock`, `pend` and `ovr` are 0.
  - State is IDLE, `cmd_valid=0`, `cmd_id=0`.
  - `last = N_BTN-1`, so button 0 has first priority.
- Reset asserted mid-offer drops the offer and all pending events immediately, asynchronously.

## Timing

Let `btn[i]` rise before edge E0.
- E0: `s0` becomes 1.
- E1: `s1` becomes 1 and `rise` is combinationally high.
- E2: `pend` set and `lock` loaded.
- E3: state OFFER, `cmd_valid=1`.

Further timing rules:
- Minimum input-to-`cmd_valid` latency is 3 cycles.
- With `cmd_ready` tied high, throughput is one command per 2 cycles: the OFFER cycle followed by an IDLE cycle.
- A button held high produces exactly one event. A release followed by a new press is needed after the lockout expires.
- Lockout expires `LOCKOUT_CYC` cycles after the accepted rise. A rise detected on the cycle `lock` reaches 0 is accepted.

## Structure

- Shared header/package `btn_pkg`:
  - FSM state encodings `ST_IDLE` and `ST_OFFER`.
  - Default `LOCKOUT_CYC`.
- Sub-module `btn_sync_edge`:
  - Clock, reset and a single raw button in; `rise` out.
  - Contains the 3-flop chain and the lockout counter.
  - Instantiated `N_BTN` times in a generate loop.
- Top level holds `pend`, `ovr`, the round-robin selector and the FSM.

## Test plan

Bench uses `LOCKOUT_CYC=8` and `N_BTN=4`.
- Single press: `btn=4'b0010` held for 20 cycles, `cmd_ready=1` -> `cmd_valid` high for exactly one cycle at E3 with `cmd_id=1`, then `pend=0`. No second event.
- Bounce: `btn[0]` toggles 1,0,1,0,1 on consecutive cycles and then stays high -> exactly one command with `cmd_id=0`, `ovr=0`.
- Round-robin: all four buttons rise in the same cycle, `cmd_ready=1` -> `cmd_id` sequence 0,1,2,3, with `cmd_valid` high on alternating cycles. Repeat after lockout with `last=3` -> order 0,1,2,3 again. Seed `last=1` by pressing button 1 alone first -> order 2,3,0,1.
- Backpressure and overrun: `cmd_ready=0`; button 2 pressed twice, 12 cycles apart -> `cmd_id=2` stable throughout and `ovr=4'b0100`. Raise `cmd_ready` -> one handshake only. Then `ovr_clr` -> `ovr=0`.
- Set/clear collision: button 3 accepted rise in the same cycle as the handshake for `cmd_id=3` -> `pend[3]` stays 1 and a second offer with `cmd_id=3` follows.
- Reset mid-offer: pull `rst` low while `cmd_valid=1` -> `cmd_valid` drops to 0 without waiting for a clock. After release, no command appears until a new press.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared constants for the button event arbiter: FSM encodings and the
// default lockout length (20 ms at 100 MHz).
package btn_pkg;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_OFFER = 1'b1;

   localparam int LOCKOUT_CYC_DEF = 2_000_000;

endpackage

// File: rtl/btn_sync_edge.sv
// Per-button front end: three-flop synchroniser, rising-edge detect and a
// lockout counter that suppresses bounce after each accepted rise.
module btn_sync_edge
   import btn_pkg::*;
#(
   parameter int LOCKOUT_CYC = LOCKOUT_CYC_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic rise
);

   localparam int                LOCK_W    = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;
   localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCKOUT_CYC - 1);
   localparam logic [LOCK_W-1:0] LOCK_ZERO = {LOCK_W{1'b0}};
   localparam logic [LOCK_W-1:0] LOCK_ONE  = LOCK_W'(1);

   logic              s0_r;
   logic              s1_r;
   logic              s2_r;
   logic [LOCK_W-1:0] lock_r;
   logic              edge_s;

   // Raw edge from the synchronised level, qualified by an expired lockout.
   always_comb begin
      edge_s = s1_r & ~s2_r;
      rise   = edge_s & (lock_r == LOCK_ZERO);
   end

   // Three-flop synchroniser for the asynchronous button level.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s0_r <= 1'b0;
         s1_r <= 1'b0;
         s2_r <= 1'b0;
      end else begin
         s0_r <= btn;
         s1_r <= s0_r;
         s2_r <= s1_r;
      end
   end

   // Lockout counter: reload on an accepted rise, then run down to zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lock_r <= LOCK_ZERO;
      end else if (rise) begin
         lock_r <= LOCK_LOAD;
      end else if (lock_r != LOCK_ZERO) begin
         lock_r <= lock_r - LOCK_ONE;
      end else begin
         lock_r <= lock_r;
      end
   end

endmodule

// File: rtl/btn_event_arbiter.sv
// Button event arbiter: one pending bit per button, sticky overrun flags and
// a round-robin grant offered over a valid/ready command channel.
module btn_event_arbiter
   import btn_pkg::*;
#(
   parameter int N_BTN       = 4,
   parameter int LOCKOUT_CYC = LOCKOUT_CYC_DEF,
   parameter int ID_W        = $clog2(N_BTN)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] btn,
   output logic             cmd_valid,
   output logic [ID_W-1:0]  cmd_id,
   input  logic             cmd_ready,
   output logic [N_BTN-1:0] ovr,
   input  logic             ovr_clr
);

   localparam logic [ID_W-1:0]  LAST_RST = ID_W'(N_BTN - 1);
   localparam logic [ID_W-1:0]  ID_ZERO  = {ID_W{1'b0}};
   localparam logic [N_BTN-1:0] VEC_ZERO = {N_BTN{1'b0}};

   logic [N_BTN-1:0] rise_s;
   logic [N_BTN-1:0] clr_s;
   logic [N_BTN-1:0] pend_nx_s;
   logic [N_BTN-1:0] ovr_nx_s;
   logic [N_BTN-1:0] pend_r;
   logic [N_BTN-1:0] ovr_r;
   logic             hs_s;
   logic [ID_W-1:0]  sel_id_s;
   logic [0:0]       state_r;
   logic             cmd_valid_r;
   logic [ID_W-1:0]  cmd_id_r;
   logic [ID_W-1:0]  last_r;

   genvar gi;
   generate
      for (gi = 0; gi < N_BTN; gi++) begin : g_btn
         btn_sync_edge #(
            .LOCKOUT_CYC (LOCKOUT_CYC)
         ) u_sync (
            .clk  (clk),
            .rst  (rst),
            .btn  (btn[gi]),
            .rise (rise_s[gi])
         );
      end
   endgenerate

   // Next pending/overrun vectors; a same-cycle rise beats the handshake clear.
   always_comb begin
      hs_s  = cmd_valid_r & cmd_ready;
      clr_s = VEC_ZERO;
      for (int i = 0; i < N_BTN; i++) begin
         clr_s[i] = hs_s & (cmd_id_r == ID_W'(i));
      end
      pend_nx_s = (pend_r & ~clr_s) | rise_s;
      ovr_nx_s  = (ovr_clr ? VEC_ZERO : ovr_r) | (rise_s & pend_r & ~clr_s);
   end

   // Round-robin pick: the pending bit at the smallest distance past last_r.
   always_comb begin
      int   best_s;
      int   dist_s;
      logic take_s;
      best_s   = N_BTN;
      dist_s   = 0;
      take_s   = 1'b0;
      sel_id_s = ID_ZERO;
      for (int i = 0; i < N_BTN; i++) begin
         dist_s   = (i + N_BTN - 1 - int'(last_r)) % N_BTN;
         take_s   = pend_r[i] && (dist_s < best_s);
         best_s   = take_s ? dist_s : best_s;
         sel_id_s = take_s ? ID_W'(i) : sel_id_s;
      end
   end

   // Pending and sticky overrun registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend_r <= VEC_ZERO;
         ovr_r  <= VEC_ZERO;
      end else begin
         pend_r <= pend_nx_s;
         ovr_r  <= ovr_nx_s;
      end
   end

   // Two-state offer FSM; the offered id is frozen until the handshake.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= ST_IDLE;
         cmd_valid_r <= 1'b0;
         cmd_id_r    <= ID_ZERO;
         last_r      <= LAST_RST;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (pend_r != VEC_ZERO) begin
                  state_r     <= ST_OFFER;
                  cmd_valid_r <= 1'b1;
                  cmd_id_r    <= sel_id_s;
               end else begin
                  state_r     <= ST_IDLE;
                  cmd_valid_r <= 1'b0;
               end
            end
            ST_OFFER: begin
               if (cmd_ready) begin
                  state_r     <= ST_IDLE;
                  cmd_valid_r <= 1'b0;
                  last_r      <= cmd_id_r;
               end else begin
                  state_r     <= ST_OFFER;
                  cmd_valid_r <= 1'b1;
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               cmd_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign cmd_valid = cmd_valid_r;
   assign cmd_id    = cmd_id_r;
   assign ovr       = ovr_r;

endmodule
